// File: rtl/pal_timing_sequencer.sv
// PAL 625-line interlaced raster sequencer running at 16x subcarrier; every output is registered.
// Defining PAL_TIMING_25HZ_OFFSET_EN adds the 25 Hz subcarrier offset (16 extra phase steps per frame).
`timescale 1ns/1ps
module pal_timing_sequencer #(
    parameter int LINE_CYCLES   = 4540,
    parameter int HSYNC_CYCLES  = 333,
    parameter int BURST_START   = 397,
    parameter int BURST_CYCLES  = 160,
    parameter int ACTIVE_START  = 745,
    parameter int ACTIVE_CYCLES = 3689
) (
    input  logic       phaseClock,
    input  logic       reset,
    output logic [3:0] subcarrierPhase,
    output logic       blank,
    output logic       sync,
    output logic       burst,
    output logic       oddFrame,
    output logic       oddLine,
    output logic       active,
    output logic       lineStart,
    output logic       frameStart,
    output logic [9:0] lineNum
);
    localparam int HW          = $clog2(LINE_CYCLES);
    localparam int HALF_CYCLES = LINE_CYCLES / 2;
    localparam int EQ_SYNC     = HSYNC_CYCLES / 2;
    localparam int BROAD_SYNC  = HALF_CYCLES - HSYNC_CYCLES;
    // First half-line index of each five-half-line equalising / broad group.
    localparam int EQ_STARTS [4]    = '{5, 620, 630, 1245};
    localparam int BROAD_STARTS [2] = '{0, 625};

    logic [HW-1:0] hcount_reg, hcount_next;
    logic [9:0]    line_reg, line_next;
    logic          parity_reg, parity_next;
    logic [3:0]    phase_reg, phase_next;
    logic          line_end, offset_step;

    int h_int, line_int, half_idx, half_off;
    logic [3:0] eq_hit;
    logic [1:0] broad_hit;

    logic sync_next, blank_next, burst_next, active_next;
    logic line_start_next, frame_start_next, odd_line_next;
    logic vblank_line, burst_line, in_window, in_burst;

    assign h_int    = 32'(hcount_reg);
    assign line_int = 32'(line_reg);
    assign half_idx = 2 * (line_int - 1) + ((h_int >= HALF_CYCLES) ? 1 : 0);
    assign half_off = (h_int >= HALF_CYCLES) ? h_int - HALF_CYCLES : h_int;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_eq
            assign eq_hit[gi] = (half_idx >= EQ_STARTS[gi]) && (half_idx < EQ_STARTS[gi] + 5);
        end
        for (gi = 0; gi < 2; gi++) begin : g_broad
            assign broad_hit[gi] = (half_idx >= BROAD_STARTS[gi]) && (half_idx < BROAD_STARTS[gi] + 5);
        end
    endgenerate

    assign line_end    = (h_int == LINE_CYCLES - 1);
    assign hcount_next = line_end ? '0 : hcount_reg + 1'b1;
    assign line_next   = !line_end ? line_reg : ((line_reg == 10'd625) ? 10'd1 : line_reg + 10'd1);
    assign parity_next = parity_reg ^ (line_end && (line_reg == 10'd625));

`ifdef PAL_TIMING_25HZ_OFFSET_EN
    logic [5:0] mod39_reg, mod39_next;

    always_comb begin
        mod39_next = mod39_reg;
        if (line_end) begin
            if (line_reg == 10'd625 || mod39_reg == 6'd38)
                mod39_next = 6'd0;
            else
                mod39_next = mod39_reg + 6'd1;
        end
    end

    always_ff @(posedge phaseClock) begin
        if (reset)
            mod39_reg <= 6'd0;
        else
            mod39_reg <= mod39_next;
    end

    // Line 625 would be a 17th hit of the mod-39 cycle; only lines 1..586 step twice.
    assign offset_step = (h_int == 0) && (mod39_reg == 6'd0) && (line_reg != 10'd625);
`else
    assign offset_step = 1'b0;
`endif

    assign phase_next = phase_reg + (offset_step ? 4'd2 : 4'd1);

    always_comb begin
        sync_next = 1'b0;
        if (|eq_hit)
            sync_next = (half_off < EQ_SYNC);
        else if (|broad_hit)
            sync_next = (half_off < BROAD_SYNC);
        else
            sync_next = (h_int < HSYNC_CYCLES);

        vblank_line = (line_int <= 22) || (line_int >= 311 && line_int <= 335) || (line_int >= 623);
        burst_line  = (line_int >= 6 && line_int <= 310) || (line_int >= 319 && line_int <= 622);
        in_window   = (h_int >= ACTIVE_START) && (h_int < ACTIVE_START + ACTIVE_CYCLES);
        in_burst    = (h_int >= BURST_START) && (h_int < BURST_START + BURST_CYCLES);

        blank_next       = sync_next || vblank_line || !in_window;
        burst_next       = burst_line && in_burst && !sync_next;
        active_next      = !vblank_line && in_window && !sync_next;
        line_start_next  = (h_int == 0);
        frame_start_next = (h_int == 0) && (line_reg == 10'd1);
        odd_line_next    = (((line_int - 1) & 2) == 0);
    end

    always_ff @(posedge phaseClock) begin
        if (reset) begin
            hcount_reg <= '0;
            line_reg   <= 10'd1;
            parity_reg <= 1'b0;
            phase_reg  <= 4'd0;
            blank      <= 1'b1;
            sync       <= 1'b0;
            burst      <= 1'b0;
            active     <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            oddFrame   <= 1'b1;
            oddLine    <= 1'b1;
            lineNum    <= 10'd1;
        end else begin
            hcount_reg <= hcount_next;
            line_reg   <= line_next;
            parity_reg <= parity_next;
            phase_reg  <= phase_next;
            blank      <= blank_next;
            sync       <= sync_next;
            burst      <= burst_next;
            active     <= active_next;
            lineStart  <= line_start_next;
            frameStart <= frame_start_next;
            oddFrame   <= ~parity_reg;
            oddLine    <= odd_line_next;
            lineNum    <= line_reg;
        end
    end

    assign subcarrierPhase = phase_reg;
endmodule

// File: doc/pal_timing_sequencer.md
Name: pal_timing_sequencer

Overview:
- Master raster sequencer for the PAL composite path. Free-running counters at 16x subcarrier produce the full 625-line interlaced timing.
- It drives the generator's subcarrierPhase, blank, sync, burst, oddFrame and oddLine inputs.
- It also provides active-video, line-start and frame-start qualifiers to the upstream pixel/YUV source.
- All outputs are registered. They update once per phaseClock and are aligned to the same counter state.

Parameters:
- LINE_CYCLES, 4540, phaseClock cycles per line (64 us; 283.75 subcarrier cycles x 16).
- HSYNC_CYCLES, 333, normal line sync width (4.7 us).
- BURST_START, 397, hCount at which burst begins (5.6 us).
- BURST_CYCLES, 160, burst length (10 subcarrier cycles).
- ACTIVE_START, 745, first active-video hCount (10.5 us).
- ACTIVE_CYCLES, 3689, active-video length (52 us).

Ports:
- phaseClock  in  1  clock, 16x subcarrier.
- reset  in  1  synchronous, active-high.
- subcarrierPhase  out  4  subcarrier phase, 0..15.
- blank  out  1  blanking interval.
- sync  out  1  sync tip.
- burst  out  1  colour burst window.
- oddFrame  out  1  high in fields 1,2,5,6,...
- oddLine  out  1  high in lines 1,2,5,6,... of the frame.
- active  out  1  pixel data valid; the upstream source must present y/u/v.
- lineStart  out  1  one-cycle strobe at hCount==0.
- frameStart  out  1  one-cycle strobe at hCount==0 of line 1.
- lineNum  out  10  current frame line, 1..625.

Behaviour:
- Reset: reset is synchronous, active-high; clock is phaseClock. While reset is high:
  - Counters: hCount=0, lineNum=1, frame parity=0.
  - Outputs: subcarrierPhase=0, blank=1, sync=0, burst=0, active=0, lineStart=0, frameStart=0, oddFrame=1, oddLine=1.
- Reset mid-line restarts cleanly at (hCount 0, line 1) on the first cycle after deassertion. No partial state survives.
- Latency: outputs on cycle N+1 reflect the counter state at cycle N. The first cycle after reset therefore shows lineStart=1 and frameStart=1.
- hCount:
  - Counts 0..LINE_CYCLES-1.
  - On wrap, lineNum increments; 625 wraps to 1. That wrap toggles frame parity.
- subcarrierPhase increments by 1 mod 16 every clock, independent of hCount. LINE_CYCLES mod 16 = 12, which gives the natural quarter-line offset.
- Half-line index: h = 2*(lineNum-1) + (hCount >= LINE_CYCLES/2). Within the half-line, offset o = hCount mod (LINE_CYCLES/2).
- Vertical regions, by h:
  - Pre-equalising: h 620..624 and 1245..1249.
  - Broad: h 625..629 and 0..4.
  - Post-equalising: h 630..634 and 5..9.
- Sync:
  - Equalising half-lines: sync = (o < HSYNC_CYCLES/2).
  - Broad half-lines: sync = (o < LINE_CYCLES/2 - HSYNC_CYCLES).
  - All other lines: sync = (hCount < HSYNC_CYCLES). No mid-line pulse.
- Vertical-blanked lines: 1..22, 311..335, 623..625.
- Active lines: 23..310 and 336..622.
- blank:
  - High whenever sync=1.
  - High for the whole of any vertical-blanked line.
  - On active lines, high outside [ACTIVE_START, ACTIVE_START+ACTIVE_CYCLES).
- active = ~blank on active lines, within the active window; 0 elsewhere.
- burst:
  - Asserted for hCount in [BURST_START, BURST_START+BURST_CYCLES).
  - Only on lines 6..310 and 319..622.
  - Never on lines that contain any equalising or broad half-line.
  - burst implies blank=1 and sync=0.
- oddLine = ~((lineNum-1)[1]).
- oddFrame: 1 in the first frame after reset; toggles at every frameStart thereafter.
- Simultaneous events: at frame wrap, lineStart, frameStart and the oddFrame toggle all appear on the same output cycle.
- Priority: sync > burst > active.
- Invariant: sync and burst are never both high.

Optional Feature:
- Macro: PAL_TIMING_25HZ_OFFSET_EN.
- Defined: implements the 25 Hz subcarrier offset.
  - At hCount==0 of lines 1+39k (k=0..15; lines 1,40,...,586), subcarrierPhase advances by 2 instead of 1.
  - This gives exactly 16 extra phase steps per frame.
  - Uses a mod-39 line counter that is reset with the other counters.
- Undefined: subcarrierPhase always advances by 1. The mod-39 counter is absent.

Test Plan:
- Release reset -> next cycle: lineStart=1, frameStart=1, lineNum=1, sync=1 (broad), oddFrame=1, oddLine=1, subcarrierPhase=1.
- Line 100, sweep hCount -> sync high 333 cycles; burst high hCount 397..556; active high hCount 745..4433; blank covers all other cycles.
- Lines 1..5 and 311..318 -> broad pulses 1937 cycles at h 0..4 and 625..629; equalising pulses 166 cycles at h 5..9, 620..624 and 630..634; burst=0 and active=0 throughout.
- Run 2 frames -> oddFrame pattern 1,0,1; frameStart period 2,837,500 cycles; oddLine pattern over lines 1..4 = 1,1,0,0.
- Assert reset at line 200, hCount 2000, for 3 cycles -> after release, outputs identical to the post-reset sequence.
- With PAL_TIMING_25HZ_OFFSET_EN defined -> subcarrierPhase at frameStart of frame 2 is 16 steps ahead of the macro-off build, i.e. (2,837,500+16) mod 16 = 12 versus 12-16 mod 16. Bench checks that the phase difference is 0 mod 16 while the cumulative step count differs by exactly 16.
